// File: rtl/image_pipeline.sv
// image_pipeline: RGB -> gray / negative / binary / 3x3 blur, one-cycle latency,
// single output register with ready/valid handshake on both sides.
// Optional macro IMGP_STATS_EN adds the frame_ones port, which reports the
// binary-one count of the last completed frame.
module image_pipeline #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] b,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] threshold_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel
`ifdef IMGP_STATS_EN
  ,
  output logic [CNT_W-1:0] frame_ones
`endif
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned GW = PIX_W + 8;  // 256 * max channel fits exactly
  localparam int unsigned BW = PIX_W + 4;  // blur weights sum to 16

  logic             in_xfer;
  logic [XW-1:0]    x_q, cur_x, x_d;
  logic [1:0]       y_q, cur_y, y_d;
  logic [GW-1:0]    gray_sum;
  logic [PIX_W-1:0] gray, neg, bin_pix, blur, result;
  logic             bin;
  logic [PIX_W-1:0] col_top, col_mid;
  logic [BW-1:0]    blur_sum;

  // Line buffers: lb1 holds row y-1, lb2 row y-2, indexed by column.
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];
  // Window of the two previous columns: [row][0]=col x-2, [row][1]=col x-1;
  // row 0 = y-2, row 1 = y-1, row 2 = y.
  logic [PIX_W-1:0] win_q [3][2];

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;

  // Position of the current pixel; start-of-frame forces (0,0).
  always_comb begin
    cur_x = in_sof ? '0 : x_q;
    cur_y = in_sof ? '0 : y_q;
    if (cur_x == XW'(IMG_W - 1)) begin
      x_d = '0;
      y_d = (cur_y == 2'd2) ? 2'd2 : cur_y + 2'd1;
    end else begin
      x_d = cur_x + XW'(1);
      y_d = cur_y;
    end
  end

  // Pixel arithmetic and output selection.
  always_comb begin
    gray_sum = GW'(77) * GW'(r) + GW'(150) * GW'(g) + GW'(29) * GW'(b);
    gray     = gray_sum[GW-1:8];
    neg      = ~gray;
    bin      = (gray >= threshold_val);
    bin_pix  = bin ? '1 : '0;
    col_top  = lb2[cur_x];
    col_mid  = lb1[cur_x];
    blur_sum = BW'(win_q[0][0]) + (BW'(win_q[0][1]) << 1) + BW'(col_top)
             + (BW'(win_q[1][0]) << 1) + (BW'(win_q[1][1]) << 2) + (BW'(col_mid) << 1)
             + BW'(win_q[2][0]) + (BW'(win_q[2][1]) << 1) + BW'(gray);
    blur     = blur_sum[BW-1:4];
    unique case (mode)
      2'd0:    result = gray;
      2'd1:    result = neg;
      2'd2:    result = bin_pix;
      default: result = (cur_x >= XW'(2) && cur_y == 2'd2) ? blur : gray;
    endcase
  end

  // Output register and position counters; hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_pixel <= result;
      x_q       <= x_d;
      y_q       <= y_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Line buffers and window shift; never reset, border gating hides stale data.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      lb2[cur_x]  <= col_mid;
      lb1[cur_x]  <= gray;
      win_q[0][0] <= win_q[0][1];
      win_q[1][0] <= win_q[1][1];
      win_q[2][0] <= win_q[2][1];
      win_q[0][1] <= col_top;
      win_q[1][1] <= col_mid;
      win_q[2][1] <= gray;
    end
  end

`ifdef IMGP_STATS_EN
  logic [CNT_W-1:0] acc_q;

  // Saturating per-frame ones counter, latched into frame_ones at start of frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      frame_ones <= '0;
    end else if (in_xfer) begin
      if (in_sof) begin
        frame_ones <= acc_q;
        acc_q      <= {{(CNT_W-1){1'b0}}, bin};
      end else if (bin && acc_q != '1) begin
        acc_q <= acc_q + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_image_pipeline.sv
// Self-checking bench for image_pipeline (IMG_W=4, CNT_W=4 to reach blur
// rows and counter saturation quickly). Works with or without IMGP_STATS_EN.
module tb_image_pipeline;

  localparam int PIX_W = 8;
  localparam int IMG_W = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_sof, out_valid, out_ready;
  logic [PIX_W-1:0] r, g, b, threshold_val, out_pixel;
  logic [1:0]       mode;
`ifdef IMGP_STATS_EN
  logic [CNT_W-1:0] frame_ones;
`endif

  always #5 clk = ~clk;

  image_pipeline #(.PIX_W(PIX_W), .IMG_W(IMG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .r(r), .g(g), .b(b), .mode(mode), .threshold_val(threshold_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel)
`ifdef IMGP_STATS_EN
    , .frame_ones(frame_ones)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: frame pixel history as a flat list of gray values.
  bit m_valid;
  int m_pix;
  int m_acc, m_fones;
  int fp[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gray_of(input int rr, input int gg, input int bb);
    return (77 * rr + 150 * gg + 29 * bb) / 256;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pix = 0; m_acc = 0; m_fones = 0;
    fp.delete();
  endtask

  // Compute the output for one accepted pixel from the frame history.
  task automatic model_accept(output int res);
    int gv, n, col, row, sum, w;
    if (in_sof) begin
      m_fones = m_acc;
      m_acc   = 0;
      fp.delete();
    end
    gv = gray_of(r, g, b);
    fp.push_back(gv);
    n   = fp.size() - 1;
    col = n % IMG_W;
    row = n / IMG_W;
    case (mode)
      2'd0: res = gv;
      2'd1: res = 255 - gv;
      2'd2: res = (gv >= threshold_val) ? 255 : 0;
      default: begin
        if (col >= 2 && row >= 2) begin
          sum = 0;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) begin
              w = ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1);
              sum += w * fp[n - dr * IMG_W - dc];
            end
          res = sum / 16;
        end else res = gv;
      end
    endcase
    if (gv >= threshold_val && m_acc < CMAX) m_acc++;
  endtask

  // One clock: check in_ready, predict, clock, compare outputs at edge+1.
  task automatic step();
    bit xfer;
    int nxt;
    #1;
    chk("in_ready", in_ready, (!m_valid || out_ready) ? 1 : 0);
    xfer = in_valid && (!m_valid || out_ready);
    nxt  = 0;
    if (xfer) model_accept(nxt);
    @(posedge clk);
    if (xfer) begin m_valid = 1; m_pix = nxt; end
    else if (out_ready) m_valid = 0;
    #1;
    chk("out_valid", out_valid, m_valid ? 1 : 0);
    if (m_valid) chk("out_pixel", out_pixel, m_pix);
`ifdef IMGP_STATS_EN
    chk("frame_ones", frame_ones, m_fones);
`endif
  endtask

  task automatic set_px(input int v, input int md, input bit sof);
    r = 8'(v); g = 8'(v); b = 8'(v); mode = 2'(md); in_sof = sof; in_valid = 1'b1;
  endtask

  typedef struct {
    int r, g, b, mode, thr, exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{100, 100, 100, 0,   0, 100};
    vecs[1] = '{100, 100, 100, 1,   0, 155};
    vecs[2] = '{128, 128, 128, 2, 128, 255};
    vecs[3] = '{128, 128, 128, 2, 129,   0};
    vecs[4] = '{255, 255, 255, 0,   0, 255};
    vecs[5] = '{255,   0,   0, 0,   0,  76};
    vecs[6] = '{  0, 255,   0, 1,   0, 106};
    vecs[7] = '{  0,   0, 255, 3,   0,  28};
    vecs[8] = '{  0,   0,   0, 1,   0, 255};
    vecs[9] = '{ 10,  20,  30, 2,  18, 255};

    rst = 1'b1; in_valid = 0; in_sof = 0; out_ready = 1; r = 0; g = 0; b = 0;
    mode = 0; threshold_val = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_pixel", out_pixel, 0);
`ifdef IMGP_STATS_EN
    chk("reset frame_ones", frame_ones, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-pixel vectors, each as its own frame.
    for (int i = 0; i < 10; i++) begin
      r = 8'(vecs[i].r); g = 8'(vecs[i].g); b = 8'(vecs[i].b);
      mode = 2'(vecs[i].mode); threshold_val = 8'(vecs[i].thr);
      in_sof = 1; in_valid = 1; out_ready = 1;
      step();
      chk($sformatf("vec%0d", i), out_pixel, vecs[i].exp);
      in_valid = 0; in_sof = 0;
      step();
      chk($sformatf("vec%0d drain", i), out_valid, 0);
    end

    // Blur on constant 80 for three rows, then an impulse of 160.
    threshold_val = 0; out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      set_px(80, 3, i == 0);
      step();
      chk("blur const", out_pixel, 80);
    end
    set_px(80, 3, 0);  step(); chk("blur x0", out_pixel, 80);
    set_px(80, 3, 0);  step(); chk("blur x1", out_pixel, 80);
    set_px(160, 3, 0); step(); chk("blur impulse", out_pixel, 85);
    set_px(80, 3, 0);  step(); chk("blur after impulse", out_pixel, 90);

    // Backpressure: hold output 50 for 5 cycles while 60 waits.
    set_px(50, 0, 0); step(); chk("stall first", out_pixel, 50);
    out_ready = 0; set_px(60, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall in_ready", in_ready, 0);
      chk("stall hold", out_pixel, 50);
    end
    out_ready = 1; step(); chk("stall release", out_pixel, 60);
    set_px(70, 0, 0); step(); chk("stall next", out_pixel, 70);

    // Frame of 7 pixels (4 ones), then start-of-frame at (3,1) in blur mode.
    threshold_val = 100;
    for (int i = 0; i < 7; i++) begin
      set_px((i % 2 == 0) ? 120 : 40, 3, i == 0);
      step();
    end
    set_px(33, 3, 1); step(); chk("sof pass", out_pixel, 33);
`ifdef IMGP_STATS_EN
    chk("sof frame_ones", frame_ones, 4);
`endif
    set_px(44, 3, 0); step(); chk("sof next pass", out_pixel, 44);

    // Reset mid-frame: output drops at once, next pixel restarts at (0,0).
    for (int i = 0; i < 6; i++) begin set_px(90 + i, 3, 0); step(); end
    #2 rst = 1'b1;
    #1 chk("rst out_valid", out_valid, 0);
    model_reset();
    #2 rst = 1'b0;
    in_valid = 0; step();
    for (int i = 0; i < 12; i++) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      mode = 2'd3; in_sof = 0; in_valid = 1;
      step();
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 900; i++) begin
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(9) < 7);
      in_sof = ($urandom_range(39) == 0);
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      mode = ($urandom_range(1) == 0) ? 2'd3 : 2'($urandom_range(3));
      threshold_val = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
